// File: rtl/hash_pkg.sv
// Shared types for the hash message feeder.
//   feeder_state_t : sequencing states of the feeder FSM
//   fifo_entry_t   : one buffered upstream beat {is_null, last, data}
package hash_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        FEED  = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    // is_null marks a beat that carries no byte (zero-length message or
    // empty terminator); such an entry always has last set.
    typedef struct packed {
        logic       is_null;
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    function automatic fifo_entry_t make_entry(input logic is_null,
                                               input logic last,
                                               input logic [7:0] data);
        fifo_entry_t e;
        e.is_null = is_null;
        e.last    = last;
        e.data    = data;
        return e;
    endfunction

endpackage

// File: rtl/hash_byte_fifo.sv
// Synchronous first-word-fall-through FIFO for feeder beats.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push, push_entry  write request and entry (ignored while full)
//   pop               read request (ignored while empty)
//   head              entry at the read pointer, valid while !empty
//   full, empty       registered occupancy flags
//   count             registered occupancy, 0..DEPTH
module hash_byte_fifo
    import hash_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  fifo_entry_t              push_entry,
    input  logic                     pop,
    output fifo_entry_t              head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full_reg;
    assign do_pop  = pop && !empty_reg;

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + (PTR_W + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_next = count_reg - (PTR_W + 1)'(1);
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    // full reads as set while in reset so upstream sees no room until the
    // first clock after release. Pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b1;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
            full_reg  <= (count_next == (PTR_W + 1)'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;
    assign count = count_reg;

endmodule

// File: rtl/hash_msg_feeder.sv
// Upstream feeder for the byte-serial hash core. Buffers a valid/ready byte
// stream and sequences start_msg -> bytes on load_byte -> msg_done -> wait
// for digest_ready, one message at a time.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last/s_null  upstream beat stream
//   start_msg                        one-cycle session-open pulse
//   msg_byte/valid_in                byte presented to the core
//   msg_done                         message input finished (held)
//   load_byte                        core takes msg_byte this cycle
//   digest_ready                     core digest is final
//   busy                             a message is in flight
//   msg_complete                     one-cycle pulse on digest observed
//   bytes_sent                       bytes of current/last message (saturating)
//   msg_count                        completed messages (wrapping)
module hash_msg_feeder
    import hash_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    input  logic             s_null,
    output logic             start_msg,
    output logic [7:0]       msg_byte,
    output logic             valid_in,
    output logic             msg_done,
    input  logic             load_byte,
    input  logic             digest_ready,
    output logic             busy,
    output logic             msg_complete,
    output logic [CNT_W-1:0] bytes_sent,
    output logic [CNT_W-1:0] msg_count
);

    localparam int                 FIFO_CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    feeder_state_t      state_reg;
    logic               start_msg_reg;
    logic               msg_done_reg;
    logic               busy_reg;
    logic [7:0]         msg_byte_reg;
    logic [CNT_W-1:0]   bytes_sent_reg;
    logic [CNT_W-1:0]   msg_count_reg;

    fifo_entry_t        fifo_in;
    fifo_entry_t        fifo_head;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FIFO_CW-1:0] fifo_count;
    logic               in_feed;

    // A null beat without last has no meaning and is dropped, but the
    // handshake still completes so upstream is not stalled by it.
    assign fifo_in   = make_entry(s_null, s_last, s_data);
    assign fifo_push = s_valid && !(s_null && !s_last);
    assign s_ready   = !fifo_full;

    hash_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (fifo_push),
        .push_entry (fifo_in),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign in_feed = (state_reg == FEED);

    // valid_in and msg_complete follow the FIFO head / digest_ready in the
    // same cycle so a byte is taken, or a digest acknowledged, with no
    // extra turnaround.
    assign valid_in     = in_feed && !fifo_empty && !fifo_head.is_null;
    assign msg_complete = (state_reg == DONE) && digest_ready;

    // A null head is consumed without the core's involvement.
    assign fifo_pop = in_feed && !fifo_empty && (fifo_head.is_null || load_byte);

    assign msg_byte   = valid_in ? fifo_head.data : msg_byte_reg;
    assign start_msg  = start_msg_reg;
    assign msg_done   = msg_done_reg;
    assign busy       = busy_reg;
    assign bytes_sent = bytes_sent_reg;
    assign msg_count  = msg_count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            start_msg_reg  <= 1'b0;
            msg_done_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            msg_byte_reg   <= '0;
            bytes_sent_reg <= '0;
            msg_count_reg  <= '0;
        end else begin
            if (valid_in) begin
                msg_byte_reg <= fifo_head.data;
            end
            start_msg_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Only open a session once something is buffered.
                    if (fifo_count != '0) begin
                        state_reg      <= START;
                        start_msg_reg  <= 1'b1;
                        busy_reg       <= 1'b1;
                        bytes_sent_reg <= '0;
                    end
                end
                START: begin
                    state_reg <= FEED;
                end
                FEED: begin
                    // An empty FIFO means upstream is starved: hold.
                    if (!fifo_empty) begin
                        if (fifo_head.is_null) begin
                            state_reg    <= DONE;
                            msg_done_reg <= 1'b1;
                        end else if (load_byte) begin
                            if (bytes_sent_reg != CNT_MAX) begin
                                bytes_sent_reg <= bytes_sent_reg + CNT_W'(1);
                            end
                            if (fifo_head.last) begin
                                state_reg    <= DONE;
                                msg_done_reg <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (digest_ready) begin
                        state_reg     <= IDLE;
                        msg_done_reg  <= 1'b0;
                        busy_reg      <= 1'b0;
                        msg_count_reg <= msg_count_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Self-checking bench for hash_msg_feeder: table of single messages,
// hand-written multi-cycle sequences, and a randomized run checked against
// a message-level reference model (byte stream split on last markers).
module tb_hash_msg_feeder;

    logic        clk;
    logic        reset_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_null;
    logic        start_msg;
    logic [7:0]  msg_byte;
    logic        valid_in;
    logic        msg_done;
    logic        load_byte;
    logic        digest_ready;
    logic        busy;
    logic        msg_complete;
    logic [15:0] bytes_sent;
    logic [15:0] msg_count;

    hash_msg_feeder #(
        .FIFO_DEPTH (16),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_null       (s_null),
        .start_msg    (start_msg),
        .msg_byte     (msg_byte),
        .valid_in     (valid_in),
        .msg_done     (msg_done),
        .load_byte    (load_byte),
        .digest_ready (digest_ready),
        .busy         (busy),
        .msg_complete (msg_complete),
        .bytes_sent   (bytes_sent),
        .msg_count    (msg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endfunction

    // ---------------- observation ----------------
    logic [7:0] got_bytes[$];
    int         got_lens[$];
    int         done_lens[$];
    int         start_cycs[$];
    int         complete_cycs[$];
    int         got_starts    = 0;
    int         got_completes = 0;
    int         acc_cnt       = 0;
    int         cyc           = 0;
    int         done_run      = 0;
    logic [7:0] last_presented = 8'h00;
    logic       prev_start     = 1'b0;
    logic       prev_complete  = 1'b0;

    always @(negedge clk) begin
        #2;
        cyc++;
        if (!reset_n) begin
            last_presented = 8'h00;
            prev_start     = 1'b0;
            prev_complete  = 1'b0;
            done_run       = 0;
        end else begin
            if (s_valid && s_ready) acc_cnt++;
            if (valid_in) last_presented = msg_byte;
            else check("msg_byte_hold", 32'(msg_byte), 32'(last_presented));
            if (valid_in && load_byte) got_bytes.push_back(msg_byte);
            if (start_msg) begin
                check("start_pulse_width", 32'(prev_start), 0);
                got_starts++;
                start_cycs.push_back(cyc);
            end
            if (msg_done) begin
                done_run++;
                check("done_no_valid", 32'(valid_in), 0);
            end
            if (msg_complete) begin
                check("complete_pulse_width", 32'(prev_complete), 0);
                check("complete_in_done", 32'(msg_done), 1);
                got_lens.push_back(int'(bytes_sent));
                done_lens.push_back(done_run);
                complete_cycs.push_back(cyc);
                got_completes++;
            end
            if (!msg_done) done_run = 0;
            prev_start    = start_msg;
            prev_complete = msg_complete;
        end
    end

    // ---------------- core model ----------------
    // load_mode: 0 always load, 1 random, 2 never, 3 until load_limit bytes taken
    int load_mode  = 0;
    int load_limit = 0;
    int dig_delay  = 0;
    bit rand_dig   = 0;
    bit noise_en   = 0;
    int dcnt       = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            load_byte    = 1'b0;
            digest_ready = 1'b0;
            dcnt         = 0;
        end else begin
            case (load_mode)
                0:       load_byte = 1'b1;
                1:       load_byte = 1'($urandom_range(0, 1));
                2:       load_byte = 1'b0;
                default: load_byte = (got_bytes.size() < load_limit);
            endcase
            if (msg_done) begin
                if (dcnt == 0 && rand_dig) dig_delay = $urandom_range(0, 3);
                dcnt++;
                digest_ready = (dcnt > dig_delay);
            end else begin
                dcnt = 0;
                digest_ready = (noise_en && !busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic send_beat(input logic [7:0] d, input logic last, input logic nul);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        s_null  = nul;
        #1;
        while (!s_ready && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("send_ready_timeout", 32'(s_ready), 1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_null  = 1'b0;
    endtask

    task automatic wait_completes(input int target, input int limit);
        int t;
        t = 0;
        while (got_completes < target && t < limit) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        #3;
        check("complete_timeout", 32'(got_completes >= target), 1);
        @(negedge clk);
    endtask

    task automatic clear_obs();
        got_bytes.delete();
        got_lens.delete();
        done_lens.delete();
        start_cycs.delete();
        complete_cycs.delete();
    endtask

    task automatic cmp_bytes(input string tag, input logic [7:0] exp[$]);
        check({tag, "_nbytes"}, got_bytes.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_bytes.size(); i++)
            check({tag, "_byte"}, 32'(got_bytes[i]), 32'(exp[i]));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        int         nbytes;
        bit         null_term;
        logic [7:0] first;
        int         exp_sent;
        int         dly;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] exp_q[$];
    int         model_count = 0;
    int         s0, c0, acc0;
    bit         sender_done;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3, 1'b0, 8'h61, 3, 2};   // "abc"
        vecs[1] = '{0, 1'b1, 8'h00, 0, 1};   // zero-length message
        vecs[2] = '{1, 1'b0, 8'hA5, 1, 0};
        vecs[3] = '{4, 1'b1, 8'h10, 4, 3};   // data then empty terminator
        vecs[4] = '{5, 1'b0, 8'hF0, 5, 1};

        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        s_null  = 1'b0;
        @(negedge clk);
        #3;
        check("rst_start_msg", 32'(start_msg), 0);
        check("rst_valid_in", 32'(valid_in), 0);
        check("rst_msg_done", 32'(msg_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_msg_complete", 32'(msg_complete), 0);
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_msg_byte", 32'(msg_byte), 0);
        check("rst_bytes_sent", 32'(bytes_sent), 0);
        check("rst_msg_count", 32'(msg_count), 0);
        do_reset();

        // ---- table: single messages ----
        for (int v = 0; v < 5; v++) begin
            clear_obs();
            exp_q.delete();
            s0 = got_starts;
            c0 = got_completes;
            load_mode = 0;
            dig_delay = vecs[v].dly;
            for (int i = 0; i < vecs[v].nbytes; i++) begin
                exp_q.push_back(8'(vecs[v].first + i));
                send_beat(8'(vecs[v].first + i),
                          (i == vecs[v].nbytes - 1) && !vecs[v].null_term, 1'b0);
            end
            if (vecs[v].null_term) send_beat(8'hEE, 1'b1, 1'b1);
            model_count++;
            wait_completes(c0 + 1, 200);
            #3;
            check("tbl_starts", got_starts - s0, 1);
            cmp_bytes("tbl", exp_q);
            check("tbl_ncomplete", got_lens.size(), 1);
            if (got_lens.size() > 0) begin
                check("tbl_bytes_sent_at_complete", got_lens[0], vecs[v].exp_sent);
                check("tbl_done_hold_cycles", done_lens[0], vecs[v].dly + 1);
            end
            check("tbl_msg_count", 32'(msg_count), 32'(model_count % 65536));
            check("tbl_bytes_sent_idle", 32'(bytes_sent), vecs[v].exp_sent);
            check("tbl_busy_idle", 32'(busy), 0);
            @(negedge clk);
        end

        // ---- back-pressure: 20 bytes into 16 entries ----
        clear_obs();
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(8'(8'h30 + i));
        c0 = got_completes;
        acc0 = acc_cnt;
        load_mode = 2;
        dig_delay = 0;
        sender_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) send_beat(8'(8'h30 + i), (i == 19), 1'b0);
                sender_done = 1'b1;
            end
        join_none
        repeat (40) @(negedge clk);
        #3;
        check("bp_accepted_full", acc_cnt - acc0, 16);
        check("bp_s_ready_low", 32'(s_ready), 0);
        check("bp_no_delivery", got_bytes.size(), 0);
        @(negedge clk);
        load_limit = 4;
        load_mode  = 3;
        repeat (12) @(negedge clk);
        #3;
        check("bp_popped_four", got_bytes.size(), 4);
        check("bp_accepted_all", acc_cnt - acc0, 20);
        check("bp_sender_done", 32'(sender_done), 1);
        @(negedge clk);
        load_mode = 0;
        model_count++;
        wait_completes(c0 + 1, 200);
        #3;
        cmp_bytes("bp", exp_q);
        if (got_lens.size() > 0) check("bp_bytes_sent", got_lens[0], 20);
        check("bp_msg_count", 32'(msg_count), 32'(model_count % 65536));
        @(negedge clk);

        // ---- back-to-back messages A(2) and B(1) fully buffered ----
        clear_obs();
        exp_q = '{8'hA0, 8'hA1, 8'hB0};
        c0 = got_completes;
        load_mode = 2;
        dig_delay = 2;
        send_beat(8'hA0, 1'b0, 1'b0);
        send_beat(8'hA1, 1'b1, 1'b0);
        send_beat(8'hB0, 1'b1, 1'b0);
        load_mode = 0;
        model_count += 2;
        wait_completes(c0 + 2, 300);
        #3;
        cmp_bytes("b2b", exp_q);
        check("b2b_nstarts", start_cycs.size(), 2);
        check("b2b_ncomplete", complete_cycs.size(), 2);
        if (start_cycs.size() > 1 && complete_cycs.size() > 1) begin
            check("b2b_start_gap", start_cycs[1] - complete_cycs[0], 2);
            check("b2b_lenA", got_lens[0], 2);
            check("b2b_lenB", got_lens[1], 1);
            check("b2b_doneA_hold", done_lens[0], 3);
        end
        check("b2b_msg_count", 32'(msg_count), 32'(model_count % 65536));
        @(negedge clk);

        // ---- starvation: load_byte high while upstream pauses ----
        clear_obs();
        exp_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        c0 = got_completes;
        load_mode = 0;
        dig_delay = 0;
        send_beat(8'h51, 1'b0, 1'b0);
        send_beat(8'h52, 1'b0, 1'b0);
        send_beat(8'h53, 1'b0, 1'b0);
        for (int t = 0; t < 50 && got_bytes.size() < 3; t++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #3;
            check("starve_valid_low", 32'(valid_in), 0);
            check("starve_bytes_sent", 32'(bytes_sent), 3);
            @(negedge clk);
        end
        send_beat(8'h54, 1'b0, 1'b0);
        send_beat(8'h55, 1'b1, 1'b0);
        model_count++;
        wait_completes(c0 + 1, 200);
        #3;
        cmp_bytes("starve", exp_q);
        if (got_lens.size() > 0) check("starve_len", got_lens[0], 5);
        @(negedge clk);

        // ---- reset during FEED with 5 bytes buffered ----
        load_mode = 2;
        for (int i = 0; i < 5; i++) send_beat(8'(8'h70 + i), (i == 4), 1'b0);
        repeat (3) @(negedge clk);
        #3;
        check("rstmid_busy_before", 32'(busy), 1);
        @(negedge clk);
        reset_n = 1'b0;
        #3;
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_msg_count", 32'(msg_count), 0);
        check("rstmid_bytes_sent", 32'(bytes_sent), 0);
        check("rstmid_valid_in", 32'(valid_in), 0);
        check("rstmid_msg_byte", 32'(msg_byte), 0);
        check("rstmid_s_ready", 32'(s_ready), 0);
        check("rstmid_start_msg", 32'(start_msg), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        model_count = 0;
        clear_obs();
        exp_q = '{8'hC1, 8'hC2};
        s0 = got_starts;
        c0 = got_completes;
        load_mode = 0;
        dig_delay = 1;
        #3;
        check("rstmid_idle_after", 32'(busy), 0);
        @(negedge clk);
        send_beat(8'hC1, 1'b0, 1'b0);
        send_beat(8'hC2, 1'b1, 1'b0);
        model_count++;
        wait_completes(c0 + 1, 200);
        #3;
        check("rstmid_starts", got_starts - s0, 1);
        cmp_bytes("rstmid", exp_q);
        check("rstmid_count_after", 32'(msg_count), 32'(model_count % 65536));
        @(negedge clk);

        // ---- randomized run against the message-level model ----
        begin
            int exp_lens[$];
            int nmsg;
            int len;
            bit nt;
            logic [7:0] d;
            nmsg = 25;
            clear_obs();
            exp_q.delete();
            s0 = got_starts;
            c0 = got_completes;
            load_mode = 1;
            rand_dig  = 1;
            noise_en  = 1;
            for (int m = 0; m < nmsg; m++) begin
                len = $urandom_range(0, 6);
                nt  = (len == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
                exp_lens.push_back(len);
                for (int i = 0; i < len; i++) begin
                    if ($urandom_range(0, 7) == 0) send_beat(8'($urandom), 1'b0, 1'b1);
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                    d = 8'($urandom);
                    exp_q.push_back(d);
                    send_beat(d, (i == len - 1) && !nt, 1'b0);
                end
                if (nt) send_beat(8'($urandom), 1'b1, 1'b1);
                model_count++;
            end
            wait_completes(c0 + nmsg, 4000);
            #3;
            cmp_bytes("rnd", exp_q);
            check("rnd_nstarts", got_starts - s0, nmsg);
            check("rnd_ncomplete", got_lens.size(), nmsg);
            for (int m = 0; m < nmsg && m < got_lens.size(); m++)
                check("rnd_bytes_sent", got_lens[m], exp_lens[m]);
            check("rnd_msg_count", 32'(msg_count), 32'(model_count % 65536));
            noise_en = 0;
            rand_dig = 0;
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hash_msg_feeder.md
Name: hash_msg_feeder

Overview:
- Upstream feeder for the byte-serial hash core.
- Accepts message bytes from a valid/ready byte stream with a last marker and buffers them in a small FIFO.
- Sequences the core's message protocol: start_msg pulse, byte delivery on load_byte, msg_done, then a wait for digest_ready.
- Bytes of the next message may be buffered while the current message is still hashing.

Parameters:
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2
CNT_W, 16, width of bytes_sent and msg_count counters

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
s_valid  in  1  upstream beat valid
s_ready  out  1  feeder can accept a beat
s_data  in  8  message byte
s_last  in  1  beat is the last of its message
s_null  in  1  beat carries no data; legal only with s_last (zero-length message or empty terminator)
start_msg  out  1  one-cycle pulse that opens a hashing session in the core
msg_byte  out  8  byte presented to the core
valid_in  out  1  msg_byte is valid
msg_done  out  1  message input finished
load_byte  in  1  core latches msg_byte this cycle
digest_ready  in  1  core digest is final
busy  out  1  a message is in flight (state != IDLE)
msg_complete  out  1  one-cycle pulse when a message's digest is observed ready
bytes_sent  out  CNT_W  bytes delivered for the current or last message
msg_count  out  CNT_W  messages completed since reset, wraps

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE. Reset mid-message discards FIFO contents and the in-flight message.
- Clock and reset: reset reset_n, asynchronous, active-low; clock clk.
- FIFO entry format: {null, last, data}, 10 bits.
- Push when s_valid && s_ready. s_ready = !full, registered from occupancy; no bypass when full.
- Simultaneous push and pop leaves occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
- s_null without s_last is dropped silently: no push, s_ready still honoured.
- State machine:
  - IDLE: when FIFO non-empty, go to START; clear bytes_sent.
  - START: start_msg=1 for exactly one cycle, then go to FEED.
  - FEED (head is a null entry): pop it, no valid_in, go to DONE.
  - FEED (head is a data entry): valid_in = 1 and msg_byte = head data. valid_in = 0 when FIFO is empty.
  - FEED, on load_byte && valid_in: pop, bytes_sent++, and go to DONE if head.last.
  - FEED, load_byte with valid_in=0 (FIFO starved): no pop, no count; the core waits.
  - DONE: msg_done=1, valid_in=0, held until digest_ready=1. Then msg_complete=1 for one cycle, msg_count++, go to IDLE.
- IDLE ignores digest_ready.
- Earliest next start_msg is 2 cycles after msg_complete (IDLE, then START).
- start_msg never asserts while the FIFO is empty.
- msg_byte holds its last value when valid_in=0.
- bytes_sent saturates at all-ones.
- msg_count wraps.
- load_byte outside FEED is ignored.

Decomposition:
- Shared package (hash_pkg): feeder state enum {IDLE, START, FEED, DONE} and the FIFO entry struct {null, last, data[7:0]}.
- One sub-module: hash_byte_fifo. Synchronous FIFO with push/pop/full/empty/count, parameter DEPTH, async active-low reset.
- Sequencing FSM and counters live in the top.

Test Plan:
1. Bytes 0x61,0x62,0x63 (last on 0x63) pushed; core model pulses load_byte once per cycle in FEED -> one start_msg pulse, then msg_byte 0x61,0x62,0x63 with valid_in; msg_done holds; digest_ready -> msg_complete pulse, bytes_sent=3, msg_count=1.
2. Zero-length message: single beat s_null=1, s_last=1 -> start_msg, no valid_in, msg_done, then msg_complete with bytes_sent=0.
3. Back-pressure: push 20 bytes, FIFO_DEPTH=16, no load_byte -> s_ready falls after 16 accepted; after 4 load_byte pops, all 20 delivered in order with no loss or duplication.
4. Back-to-back messages: msg A (2 bytes) and msg B (1 byte) fully buffered -> A delivered, msg_done until digest_ready; B's start_msg exactly 2 cycles after A's msg_complete; msg_count=2.
5. Starvation: load_byte held high while upstream pauses 5 cycles mid-message -> valid_in=0 for those cycles, bytes_sent unchanged, no extra pops, delivery resumes in order.
6. Assert reset_n low during FEED with 5 bytes buffered -> all outputs 0, FIFO empty, state IDLE; next message proceeds normally from start_msg.
